fp_addsub_result_buf: RTL and testbench
=======================================

Name: fp_addsub_result_buf

Overview:
- Downstream collector for the FP add/sub unit. The unit has no stall input and always reports ready, so this block absorbs its Valid/Res/Tag/Status stream into a DEPTH-entry FIFO.
- It presents results to the cluster interconnect through a valid/ack handshake.
- It throttles new issues to the unit with a credit scheme: fifo occupancy plus in-flight operations never exceeds DEPTH, so no result is ever lost.
- It also keeps a sticky accumulator of exception flags for the FP CSR.

Parameters:
- FP_WIDTH, 32, result width.
- TAG_WIDTH, 5, tag width carried with each result.
- STAT_WIDTH, 5, status flag width (NUSFLAGS_ADDSUB).
- DEPTH, 4, FIFO entries and total credit count; must be >= 1.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  synchronous active-high reset.
- Issue_i  in  1  an operation is launched into the add/sub unit this cycle (same signal as the unit's En_i).
- Ready_o  out  1  a credit is available, so Issue_i is legal.
- Valid_i  in  1  result valid from the unit.
- Res_i  in  FP_WIDTH  result from the unit.
- Tag_i  in  TAG_WIDTH  tag from the unit.
- Status_i  in  STAT_WIDTH  status from the unit.
- Valid_o  out  1  head entry valid.
- Res_o  out  FP_WIDTH  head result.
- Tag_o  out  TAG_WIDTH  head tag.
- Status_o  out  STAT_WIDTH  head status.
- Ack_i  in  1  consumer takes the head entry.
- StatusAcc_o  out  STAT_WIDTH  sticky OR of Status of all popped entries.
- StatusClr_i  in  1  clears StatusAcc_o.
- Err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_i high at a clock edge) produces:
  - wr_ptr, rd_ptr, count, inflight all 0;
  - Valid_o 0; Res_o, Tag_o, Status_o all 0;
  - StatusAcc_o 0, Err_o 0, Ready_o 1.
- Reset mid-operation discards FIFO contents and in-flight credits. Results arriving after reset are counted as errors (inflight is 0).
- State:
  - circular FIFO with wr_ptr/rd_ptr wrapping at DEPTH (DEPTH need not be a power of 2);
  - count in 0..DEPTH;
  - inflight in 0..DEPTH.
- Ready_o = (count + inflight) < DEPTH.
  - Decoded from registers only; no combinational path from Issue_i, Valid_i or Ack_i.
  - A pop in the current cycle does not raise Ready_o until the next cycle.
- Issue_i increments inflight. Valid_i decrements it. Both in the same cycle leave it unchanged.
- Issue_i while Ready_o=0:
  - sets Err_o;
  - inflight still increments, saturating at DEPTH.
- Valid_i while inflight=0:
  - sets Err_o;
  - inflight stays 0;
  - the result is still pushed if there is space.
- Push: Valid_i writes {Res_i, Tag_i, Status_i} at wr_ptr and wr_ptr advances.
- Pop: Valid_o && Ack_i advances rd_ptr.
- Ack_i while Valid_o=0 is ignored; it is not an error.
- Push and pop in the same cycle: count unchanged, and the push is allowed even when count=DEPTH.
- Push while full with no pop: the data is dropped, Err_o is set, and the FIFO is unchanged.
- Latency: no bypass. A result on Valid_i in cycle N appears on Valid_o in cycle N+1 if the FIFO was empty.
- Valid_o = (count != 0).
- Res_o, Tag_o, Status_o show the head entry when Valid_o=1 and are forced to 0 when Valid_o=0.
- Order of results is preserved.
- StatusAcc_o update on a pop: StatusAcc_o <= (StatusClr_i ? 0 : StatusAcc_o) | Status_o.
  - StatusClr_i without a pop clears it to 0.
  - A simultaneous clear and pop leaves exactly the popped status.
- Err_o is cleared only by reset.

Test Plan:
- Basic transfer. Bench models the unit with latency 2. After reset, Issue_i for 1 cycle; Valid_i 2 cycles later with Res 0x3F800000, Tag 3, Status 0x01; Ack_i held high.
  -> Valid_o high exactly 1 cycle later with Res_o 0x3F800000, Tag_o 3.
  -> StatusAcc_o becomes 0x01 after the pop.
- Credits with DEPTH=4 and Ack_i low: issue 4 back-to-back.
  -> Ready_o falls right after the 4th issue.
  -> All 4 results are stored, count=4, Ready_o stays low.
  -> One Ack_i raises Ready_o the following cycle.
  -> Err_o stays 0 throughout.
- Full plus simultaneous push and pop. Construct count=4, inflight=1 by an illegal issue.
  -> Err_o=1.
  -> When Valid_i coincides with Ack_i, the push is accepted and count stays 4.
  -> The drained order equals the issue order, checked by tags 0..4.
- Push into a full FIFO without a pop.
  -> Entry dropped, Err_o=1, the existing 4 entries are intact and drained in order.
- Status clear: pop entries with Status 0x04 and then 0x10.
  -> StatusAcc_o = 0x14.
  -> StatusClr_i together with a pop of Status 0x02 gives 0x02.
  -> StatusClr_i alone gives 0x00.
- Reset mid-operation: rst_i asserted with count=2 and inflight=1.
  -> Next cycle: Valid_o 0, Ready_o 1, outputs 0.
  -> The late Valid_i afterwards sets Err_o and pushes 1 entry.

Source files
------------

// File: rtl/fp_addsub_result_buf.sv
// Result collector for the FP add/sub unit: FIFO, issue credits,
// sticky status accumulator and sticky protocol-error flag.
//
// Ports:
//   clk_i, rst_i        rising-edge clock, synchronous active-high reset
//   Issue_i, Ready_o    issue strobe to the unit / credit available
//   Valid_i, Res_i,
//   Tag_i, Status_i     result stream from the unit (never stalled)
//   Valid_o, Res_o,
//   Tag_o, Status_o     head entry (zeroed while Valid_o is low)
//   Ack_i               consumer takes the head entry
//   StatusAcc_o         sticky OR of popped Status values
//   StatusClr_i         clears StatusAcc_o
//   Err_o               sticky protocol error, cleared only by reset
module fp_addsub_result_buf #(
    parameter int FP_WIDTH   = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int STAT_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  Issue_i,
    output logic                  Ready_o,
    input  logic                  Valid_i,
    input  logic [FP_WIDTH-1:0]   Res_i,
    input  logic [TAG_WIDTH-1:0]  Tag_i,
    input  logic [STAT_WIDTH-1:0] Status_i,
    output logic                  Valid_o,
    output logic [FP_WIDTH-1:0]   Res_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    output logic [STAT_WIDTH-1:0] Status_o,
    input  logic                  Ack_i,
    output logic [STAT_WIDTH-1:0] StatusAcc_o,
    input  logic                  StatusClr_i,
    output logic                  Err_o
);

    localparam int EW = FP_WIDTH + TAG_WIDTH + STAT_WIDTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] L_PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] L_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] L_ONE      = CW'(1);

    logic [EW-1:0]         r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_inflight;
    logic [STAT_WIDTH-1:0] r_acc;
    logic                  r_err;

    logic [EW-1:0]         w_head;
    logic [CW:0]           w_used;
    logic                  w_valid;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_over;
    logic                  w_under;
    logic [PW-1:0]         w_wr_ptr_nxt;
    logic [PW-1:0]         w_rd_ptr_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic [CW-1:0]         w_inflight_nxt;
    logic [STAT_WIDTH-1:0] w_acc_nxt;

    // Credits are decoded from registers only, so a pop this
    // cycle frees its credit on the next cycle.
    assign w_used  = {1'b0, r_count} + {1'b0, r_inflight};
    assign Ready_o = (w_used < {1'b0, L_DEPTH});

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == L_DEPTH);
    assign w_head  = r_mem[r_rd_ptr];

    assign w_pop   = w_valid && Ack_i;
    // A full FIFO still accepts a push when the head leaves
    // in the same cycle.
    assign w_push  = Valid_i && (!w_full || w_pop);
    assign w_drop  = Valid_i && w_full && !w_pop;
    assign w_over  = Issue_i && !Ready_o;
    assign w_under = Valid_i && (r_inflight == '0);

    assign Valid_o     = w_valid;
    assign Res_o       = w_valid ? w_head[EW-1 -: FP_WIDTH] : '0;
    assign Tag_o       = w_valid ? w_head[STAT_WIDTH +: TAG_WIDTH] : '0;
    assign Status_o    = w_valid ? w_head[STAT_WIDTH-1:0] : '0;
    assign StatusAcc_o = r_acc;
    assign Err_o       = r_err;

    // Pointers wrap explicitly so DEPTH need not be a power of 2.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_push) begin
            w_wr_ptr_nxt = (r_wr_ptr == L_PTR_LAST) ? '0
                         : r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_nxt = (r_rd_ptr == L_PTR_LAST) ? '0
                         : r_rd_ptr + PW'(1);
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        unique case (1'b1)
            (w_push && !w_pop): w_count_nxt = r_count + L_ONE;
            (w_pop && !w_push): w_count_nxt = r_count - L_ONE;
            default:            w_count_nxt = r_count;
        endcase
    end

    // Over-issue saturates at DEPTH; a stray result never
    // drives the in-flight count below zero.
    always_comb begin
        w_inflight_nxt = r_inflight;
        unique case (1'b1)
            (Issue_i && !Valid_i): begin
                if (r_inflight != L_DEPTH) begin
                    w_inflight_nxt = r_inflight + L_ONE;
                end
            end
            (Valid_i && !Issue_i): begin
                if (r_inflight != '0) begin
                    w_inflight_nxt = r_inflight - L_ONE;
                end
            end
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    // A clear together with a pop keeps only the popped status.
    always_comb begin
        w_acc_nxt = r_acc;
        if (w_pop) begin
            w_acc_nxt = (StatusClr_i ? '0 : r_acc) | Status_o;
        end else if (StatusClr_i) begin
            w_acc_nxt = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_acc      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            r_acc      <= w_acc_nxt;
            r_err      <= r_err | w_over | w_under | w_drop;
        end
    end

    // Storage needs no reset: outputs are masked by Valid_o.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_mem[r_wr_ptr] <= {Res_i, Tag_i, Status_i};
        end
    end

endmodule

// File: tb/tb_fp_addsub_result_buf.sv
// Bench for fp_addsub_result_buf: latency-2 unit model, queue
// reference model and a decoupled pop scoreboard.
module tb_fp_addsub_result_buf;

    localparam int FW    = 32;
    localparam int TW    = 5;
    localparam int SW    = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [FW-1:0] res;
        logic [TW-1:0] tag;
        logic [SW-1:0] st;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          Issue_i;
    logic          Ready_o;
    logic          Valid_i;
    logic [FW-1:0] Res_i;
    logic [TW-1:0] Tag_i;
    logic [SW-1:0] Status_i;
    logic          Valid_o;
    logic [FW-1:0] Res_o;
    logic [TW-1:0] Tag_o;
    logic [SW-1:0] Status_o;
    logic          Ack_i;
    logic [SW-1:0] StatusAcc_o;
    logic          StatusClr_i;
    logic          Err_o;

    always #5 clk = ~clk;

    fp_addsub_result_buf #(
        .FP_WIDTH(FW), .TAG_WIDTH(TW),
        .STAT_WIDTH(SW), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .Issue_i(Issue_i), .Ready_o(Ready_o),
        .Valid_i(Valid_i), .Res_i(Res_i),
        .Tag_i(Tag_i), .Status_i(Status_i),
        .Valid_o(Valid_o), .Res_o(Res_o),
        .Tag_o(Tag_o), .Status_o(Status_o),
        .Ack_i(Ack_i), .StatusAcc_o(StatusAcc_o),
        .StatusClr_i(StatusClr_i), .Err_o(Err_o)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: buffer contents, outstanding ops, flags.
    ent_t          m_fifo[$];
    ent_t          sb[$];
    int            m_inf;
    bit            m_err;
    logic [SW-1:0] m_acc;

    // Unit model: two-stage delay line from issue to result.
    bit            pv0, pv1;
    ent_t          pd0, pd1;
    logic [TW-1:0] tag_ctr;
    int            st_sel;
    bit            res_fix;
    logic [FW-1:0] res_val;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        sb.delete();
        m_inf = 0;
        m_err = 1'b0;
        m_acc = '0;
    endtask

    function automatic bit m_ready();
        return (m_fifo.size() + m_inf) < DEPTH;
    endfunction

    task automatic check_outs();
        chk("ready", 64'(Ready_o), 64'(m_ready()));
        chk("valid", 64'(Valid_o), 64'(m_fifo.size() > 0));
        chk("err", 64'(Err_o), 64'(m_err));
        chk("acc", 64'(StatusAcc_o), 64'(m_acc));
        if (m_fifo.size() > 0)
            chk("head", 64'({Res_o, Tag_o, Status_o}),
                64'(m_fifo[0]));
        else
            chk("idle_zero", 64'({Res_o, Tag_o, Status_o}),
                64'(0));
    endtask

    task automatic model_step(input bit iss, input bit vld,
                              input bit ack, input bit clr,
                              input ent_t d);
        ent_t h;
        if (iss && !m_ready()) m_err = 1'b1;
        if (vld && m_inf == 0) m_err = 1'b1;
        if (iss && !vld)
            m_inf = (m_inf < DEPTH) ? m_inf + 1 : DEPTH;
        else if (vld && !iss && m_inf > 0)
            m_inf--;
        if (ack && m_fifo.size() > 0) begin
            h = m_fifo.pop_front();
            m_acc = (clr ? '0 : m_acc) | h.st;
        end else if (clr) begin
            m_acc = '0;
        end
        if (vld) begin
            if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(d);
                sb.push_back(d);
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    // One clock: check state, drive inputs, advance model.
    task automatic cyc(input bit iss, input bit ack,
                       input bit clr, input bit rst,
                       input bit inj);
        ent_t d;
        bit   v;
        check_outs();
        v = pv1;
        d = pd1;
        if (inj) begin
            v     = 1'b1;
            d.res = $urandom;
            d.tag = TW'($urandom);
            d.st  = SW'($urandom);
        end
        Issue_i     = iss;
        Valid_i     = v;
        Res_i       = v ? d.res : '0;
        Tag_i       = v ? d.tag : '0;
        Status_i    = v ? d.st : '0;
        Ack_i       = ack;
        StatusClr_i = clr;
        rst_i       = rst;
        if (rst) model_reset();
        else model_step(iss, v, ack, clr, d);
        pv1 = pv0;
        pd1 = pd0;
        pv0 = iss;
        if (iss) begin
            pd0.res = res_fix ? res_val : $urandom;
            pd0.tag = tag_ctr;
            pd0.st  = (st_sel >= 0) ? SW'(st_sel) : SW'($urandom);
            tag_ctr = tag_ctr + 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) cyc(0, ack, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle(3, 1'b1);
        cyc(0, 0, 0, 1, 0);
        tag_ctr = '0;
    endtask

    // Scoreboard monitor: compares every handshake pop.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_i === 1'b0 && Valid_o === 1'b1
                && Ack_i === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tot++;
                    $display("FAIL pop_unexpected: got %0h expected none",
                             {Res_o, Tag_o, Status_o});
                end else begin
                    e = sb.pop_front();
                    chk("pop_data", 64'({Res_o, Tag_o, Status_o}),
                        64'(e));
                end
            end
        end
    end

    initial begin
        int r;
        bit iss, ack, clr, rst, inj;
        rst_i = 1'b1; Issue_i = 0; Valid_i = 0; Ack_i = 0;
        StatusClr_i = 0; Res_i = '0; Tag_i = '0; Status_i = '0;
        pv0 = 0; pv1 = 0; pd0 = '0; pd1 = '0;
        st_sel = -1; res_fix = 0; res_val = '0; tag_ctr = '0;
        repeat (2) @(negedge clk);
        model_reset();

        // Basic transfer through the latency-2 unit.
        tag_ctr = 5'd3; st_sel = 1; res_fix = 1;
        res_val = 32'h3F80_0000;
        cyc(1, 1, 0, 0, 0);
        idle(4, 1'b1);
        res_fix = 0; st_sel = -1;

        // Credits: four legal issues, no acks.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        idle(4, 1'b0);
        cyc(0, 1, 0, 0, 0);
        idle(6, 1'b1);

        // Illegal fifth issue, push coinciding with a pop.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        idle(6, 1'b1);

        // Stray push into a full FIFO with no pop.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        idle(3, 1'b0);
        cyc(0, 0, 0, 0, 1);
        idle(6, 1'b1);

        // Status accumulate and clear.
        do_reset();
        st_sel = 5'h04; cyc(1, 0, 0, 0, 0);
        st_sel = 5'h10; cyc(1, 0, 0, 0, 0);
        st_sel = 5'h02; cyc(1, 0, 0, 0, 0);
        st_sel = -1;
        idle(3, 1'b0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("acc_14", 64'(StatusAcc_o), 64'(5'h14));
        cyc(0, 1, 1, 0, 0);
        chk("acc_clr_pop", 64'(StatusAcc_o), 64'(5'h02));
        cyc(0, 0, 1, 0, 0);
        chk("acc_clr", 64'(StatusAcc_o), 64'(0));
        idle(2, 1'b0);

        // Reset with two stored entries and one op in flight.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2, 1'b0);
        chk("late_err", 64'(Err_o), 64'(1));
        idle(3, 1'b1);

        // Randomized traffic, mostly legal issues.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(999);
            iss = m_ready() ? ($urandom_range(99) < 60)
                            : ($urandom_range(99) < 3);
            ack = ($urandom_range(99) < 50);
            clr = ($urandom_range(99) < 5);
            rst = (r < 4);
            inj = !pv1 && (r >= 990);
            cyc(iss, ack, clr, rst, inj);
        end

        idle(DEPTH + 4, 1'b1);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
